glitch_sequencer: RTL and testbench

Upstream control stage for `serializer64`. It assembles a 64-bit glitch waveform from a byte stream, typically the host/UART command path. Once armed, it waits for a target trigger edge, applies a programmable delay, and then drives the serializer's `en`/`in` pair for a programmable number of shots separated by a programmable gap. It owns all shot timing; the serializer only shifts bits.

---
 rtl/glitch_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: assembles a 64-bit glitch pattern from a byte stream and,
// once armed, fires it through serializer64 after a trigger edge with a
// programmable delay, shot count and inter-shot gap.
module glitch_sequencer #(
  parameter int unsigned DELAY_W  = 16,
  parameter int unsigned REPEAT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          load_data,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                arm,
  input  logic                abort,
  input  logic                trigger,
  input  logic [DELAY_W-1:0]  delay,
  input  logic [DELAY_W-1:0]  gap,
  input  logic [REPEAT_W-1:0] shots,
  output logic [63:0]         pattern,
  output logic                ser_en,
  output logic                pattern_ready,
  output logic                armed,
  output logic                busy,
  output logic                done
);

  // Shared timer covers delay, gap+1 and the 65-cycle shot window.
  localparam int unsigned TIMER_W  = (DELAY_W + 1 > 7) ? DELAY_W + 1 : 7;
  localparam int unsigned FIRE_LEN = 65;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_FIRE,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [REPEAT_W-1:0] shots_left_q, shots_left_d;
  logic [DELAY_W-1:0]  delay_lat_q, delay_lat_d;
  logic [DELAY_W-1:0]  gap_lat_q, gap_lat_d;
  logic                trig_prev_q, trig_prev_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [63:0]         pattern_q, pattern_d;
  logic                pattern_ready_q, pattern_ready_d;
  logic                load_ready_q, load_ready_d;
  logic                ser_en_q, ser_en_d;
  logic                armed_q, armed_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                trig_rise;

  // Next-state, timer, loader and registered-output computation.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    shots_left_d    = shots_left_q;
    delay_lat_d     = delay_lat_q;
    gap_lat_d       = gap_lat_q;
    trig_prev_d     = trigger;
    byte_cnt_d      = byte_cnt_q;
    pattern_d       = pattern_q;
    pattern_ready_d = pattern_ready_q;
    done_d          = 1'b0;
    accept          = load_valid && load_ready_q;
    trig_rise       = trigger && !trig_prev_q;

    case (state_q)
      S_IDLE: begin
        if (arm && pattern_ready_q && !abort) begin
          state_d      = S_ARMED;
          delay_lat_d  = delay;
          gap_lat_d    = gap;
          shots_left_d = (shots == '0) ? REPEAT_W'(1) : shots;
        end
      end
      S_ARMED: begin
        if (trig_rise) begin
          state_d = S_DELAY;
          timer_d = TIMER_W'(delay_lat_q);
        end
      end
      S_DELAY: begin
        if (timer_q == '0) begin
          state_d = S_FIRE;
          timer_d = TIMER_W'(FIRE_LEN - 1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_FIRE: begin
        if (timer_q == '0) begin
          shots_left_d = shots_left_q - REPEAT_W'(1);
          if (shots_left_q == REPEAT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            timer_d = TIMER_W'(gap_lat_q) + TIMER_W'(1);
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_FIRE;
          timer_d = TIMER_W'(FIRE_LEN - 1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    if (accept) begin
      pattern_d  = {pattern_q[55:0], load_data};
      byte_cnt_d = byte_cnt_q + 3'd1;
      if (byte_cnt_q == 3'd7) begin
        pattern_ready_d = 1'b1;
      end else if ((byte_cnt_q == 3'd0) && pattern_ready_q) begin
        pattern_ready_d = 1'b0;
      end
    end

    // Status flags track the state being entered so they line up with it.
    load_ready_d = (state_d == S_IDLE);
    armed_d      = (state_d == S_ARMED);
    busy_d       = (state_d == S_DELAY) || (state_d == S_FIRE) || (state_d == S_GAP);
    ser_en_d     = (state_d == S_FIRE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      shots_left_q    <= '0;
      delay_lat_q     <= '0;
      gap_lat_q       <= '0;
      trig_prev_q     <= 1'b0;
      byte_cnt_q      <= '0;
      pattern_q       <= '0;
      pattern_ready_q <= 1'b0;
      load_ready_q    <= 1'b0;
      ser_en_q        <= 1'b0;
      armed_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      shots_left_q    <= shots_left_d;
      delay_lat_q     <= delay_lat_d;
      gap_lat_q       <= gap_lat_d;
      trig_prev_q     <= trig_prev_d;
      byte_cnt_q      <= byte_cnt_d;
      pattern_q       <= pattern_d;
      pattern_ready_q <= pattern_ready_d;
      load_ready_q    <= load_ready_d;
      ser_en_q        <= ser_en_d;
      armed_q         <= armed_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign load_ready    = load_ready_q;
  assign pattern       = pattern_q;
  assign ser_en        = ser_en_q;
  assign pattern_ready = pattern_ready_q;
  assign armed         = armed_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: timeline-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_glitch_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    load_data;
  logic          load_valid;
  logic          load_ready;
  logic          arm;
  logic          abort;
  logic          trigger;
  logic [DW-1:0] delay;
  logic [DW-1:0] gap;
  logic [RW-1:0] shots;
  logic [63:0]   pattern;
  logic          ser_en;
  logic          pattern_ready;
  logic          armed;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  glitch_sequencer #(.DELAY_W(DW), .REPEAT_W(RW)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .arm(arm), .abort(abort), .trigger(trigger),
    .delay(delay), .gap(gap), .shots(shots), .pattern(pattern),
    .ser_en(ser_en), .pattern_ready(pattern_ready), .armed(armed),
    .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode is idle/armed/running; while running, outputs are
  // derived from the cycle offset since the trigger edge was seen.
  bit [63:0] m_pattern;
  int        m_bytes;
  bit        m_pready, m_load_ready, m_ser_en, m_armed, m_busy, m_done, m_trig_prev;
  int        m_mode;
  longint    m_D, m_G, m_S, m_cyc, m_tdet;

  always @(posedge clk) begin : model_p
    int     old_mode;
    bit     acc;
    longint s, per, total;
    m_cyc++;
    if (rst) begin
      m_pattern = '0; m_bytes = 0; m_pready = 0; m_load_ready = 0;
      m_ser_en = 0; m_armed = 0; m_busy = 0; m_done = 0;
      m_trig_prev = 0; m_mode = 0;
    end else begin
      old_mode = m_mode;
      acc      = load_valid && m_load_ready;
      m_done   = 0;
      if (old_mode != 0 && abort) begin
        m_mode = 0;
      end else if (old_mode == 0) begin
        if (arm && m_pready && !abort) begin
          m_mode = 1;
          m_D = longint'(delay);
          m_G = longint'(gap);
          m_S = (shots == 0) ? 1 : longint'(shots);
        end
      end else if (old_mode == 1) begin
        if (trigger && !m_trig_prev) begin
          m_mode = 2;
          m_tdet = m_cyc;
        end
      end else begin
        per   = 67 + m_G;
        total = m_S * per - m_G - 2;
        s     = m_cyc - (m_tdet + 1 + m_D);
        if (s == total) begin
          m_mode = 0;
          m_done = 1;
        end
      end
      m_ser_en = 0;
      if (m_mode == 2) begin
        per      = 67 + m_G;
        total    = m_S * per - m_G - 2;
        s        = m_cyc - (m_tdet + 1 + m_D);
        m_ser_en = (s >= 0) && (s < total) && ((s % per) < 65);
      end
      if (acc) begin
        m_pattern = {m_pattern[55:0], load_data};
        if (m_bytes == 7) begin
          m_pready = 1;
          m_bytes  = 0;
        end else begin
          if (m_bytes == 0 && m_pready) m_pready = 0;
          m_bytes++;
        end
      end
      m_trig_prev  = trigger;
      m_load_ready = (m_mode == 0);
      m_armed      = (m_mode == 1);
      m_busy       = (m_mode == 2);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pattern",       pattern,              m_pattern);
      chk("ser_en",        64'(ser_en),          64'(m_ser_en));
      chk("pattern_ready", 64'(pattern_ready),   64'(m_pready));
      chk("load_ready",    64'(load_ready),      64'(m_load_ready));
      chk("armed",         64'(armed),           64'(m_armed));
      chk("busy",          64'(busy),            64'(m_busy));
      chk("done",          64'(done),            64'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    for (int k = 0; k < 20 && !load_ready; k++) tick();
    if (!load_ready) begin
      n_vec++; n_err++;
      $display("FAIL load_ready_timeout: got 0 expected 1");
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_arm(input int d, input int g, input int s);
    delay = DW'(d);
    gap   = DW'(g);
    shots = RW'(s);
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
  endtask

  int rise, hi, last, dn, dn_at, rises, first_fall, second_rise;
  bit prev_en;

  initial begin
    rst = 1'b1; load_data = '0; load_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    trigger = 1'b0; delay = '0; gap = '0; shots = '0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset_outputs", {pattern[57:0], ser_en, pattern_ready, armed, busy, done, load_ready}, 64'd0);
    rst = 1'b0;
    tick();
    chk("load_ready_after_reset", 64'(load_ready), 64'd1);

    // Load 01..08, arm for a single immediate shot.
    for (int i = 1; i <= 8; i++) load_byte(8'(i));
    chk("pattern_lit", pattern, 64'h0102030405060708);
    chk("pready_lit", 64'(pattern_ready), 64'd1);
    do_arm(0, 0, 1);
    chk("load_ready_armed", 64'(load_ready), 64'd0);
    chk("armed_lit", 64'(armed), 64'd1);
    trigger = 1'b1;
    rise = -1; hi = 0; last = -1; dn = 0; dn_at = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ser_en) begin hi++; last = k; if (rise < 0) rise = k; end
      if (done) begin dn++; dn_at = k; end
    end
    trigger = 1'b0;
    chk("t1_rise", 64'(rise), 64'd2);
    chk("t1_high", 64'(hi), 64'd65);
    chk("t1_last", 64'(last), 64'd66);
    chk("t1_done_cnt", 64'(dn), 64'd1);
    chk("t1_done_at", 64'(dn_at), 64'd67);

    // delay=10, gap=3, shots=3.
    do_arm(10, 3, 3);
    trigger = 1'b1;
    rise = -1; hi = 0; dn = 0; dn_at = -1; rises = 0; first_fall = -1; second_rise = -1;
    prev_en = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (ser_en && !prev_en) begin
        rises++;
        if (rise < 0) rise = k;
        else if (second_rise < 0) second_rise = k;
      end
      if (!ser_en && prev_en && first_fall < 0) first_fall = k;
      if (ser_en) hi++;
      if (done) begin dn++; dn_at = k; end
      prev_en = ser_en;
    end
    trigger = 1'b0;
    chk("t2_first_rise", 64'(rise), 64'd12);
    chk("t2_rises", 64'(rises), 64'd3);
    chk("t2_high", 64'(hi), 64'd195);
    chk("t2_low_gap", 64'(second_rise - first_fall), 64'd5);
    chk("t2_done_cnt", 64'(dn), 64'd1);
    chk("t2_done_at", 64'(dn_at), 64'd217);

    // Trigger already high at arm must not fire.
    trigger = 1'b1;
    tick(); tick();
    do_arm(0, 0, 1);
    hi = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (busy || ser_en) hi++; end
    chk("t3_no_fire", 64'(hi), 64'd0);
    chk("t3_still_armed", 64'(armed), 64'd1);
    trigger = 1'b0; tick();
    trigger = 1'b1; tick();
    chk("t3_fresh_edge", 64'(busy), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort_idle", 64'({armed, busy}), 64'd0);
    trigger = 1'b0;

    // Partial load blocks arming.
    for (int i = 1; i <= 5; i++) load_byte(8'(8'hA0 + i));
    chk("t3_partial_pready", 64'(pattern_ready), 64'd0);
    do_arm(0, 0, 1);
    chk("t3_partial_arm", 64'(armed), 64'd0);
    for (int i = 6; i <= 8; i++) load_byte(8'(8'hA0 + i));
    chk("t3_pattern2", pattern, 64'hA1A2A3A4A5A6A7A8);

    // Abort in cycle 20 of FIRE with shots=2.
    do_arm(0, 0, 2);
    trigger = 1'b1;
    for (int k = 0; k < 10 && !ser_en; k++) tick();
    for (int k = 0; k < 19; k++) tick();
    chk("t4_in_fire", 64'(ser_en), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort", {pattern, 7'(0)} >> 7, 64'hA1A2A3A4A5A6A7A8);
    chk("t4_flags", 64'({ser_en, armed, busy, done, load_ready, pattern_ready}), 64'b000011);
    dn = 0;
    for (int k = 0; k < 80; k++) begin tick(); if (done || ser_en) dn++; end
    chk("t4_no_done", 64'(dn), 64'd0);
    trigger = 1'b0;

    // Reset during GAP.
    do_arm(0, 10, 2);
    trigger = 1'b1;
    for (int k = 0; k < 10 && !ser_en; k++) tick();
    for (int k = 0; k < 100 && ser_en; k++) tick();
    chk("t5_in_gap", 64'({busy, ser_en}), 64'b10);
    rst = 1'b1; tick();
    chk("t5_reset", {pattern[57:0], ser_en, pattern_ready, armed, busy, done, load_ready}, 64'd0);
    rst = 1'b0; trigger = 1'b0;
    tick();

    // Random traffic checked against the model.
    for (int k = 0; k < 6000; k++) begin
      rst        = ($urandom_range(0, 799) == 0);
      abort      = ($urandom_range(0, 299) == 0);
      arm        = ($urandom_range(0, 15) == 0);
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) trigger = ~trigger;
      delay = DW'($urandom_range(0, 12));
      gap   = DW'($urandom_range(0, 6));
      shots = RW'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; abort = 1'b0; arm = 1'b0; load_valid = 1'b0;
    tick(); tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
